top_alarm: RTL and testbench
============================

TOP_ALARM -- requirements
Module: top_alarm

Interface
REQ-001 The block SHALL have exactly one parameter: TICK_DIV, default 1, the number of clk cycles per timing tick (legal range 1..65535).
REQ-002 Port `clk`: input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 Port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `restart`: input, 1 bit, synchronous request to acknowledge an alarm and start the hold-off period.
REQ-005 Port `ws`: input, 1 bit, window/intrusion sensor; 1 = tripped; synchronous to clk.
REQ-006 Port `CLR_WC`: input, 1 bit, synchronous clear of the window (ws) counter.
REQ-007 Port `RUN`: input, 1 bit, arm enable; 1 = armed.
REQ-008 Port `DTF`: input, 5 bits, unsigned delay-to-fire, in ticks.
REQ-009 Port `RTR`: input, 6 bits, unsigned rearm (hold-off) time, in ticks.
REQ-010 Port `active`: output, 1 bit, registered alarm output.

Function
REQ-011 A free-running prescaler SHALL generate a one-cycle tick strobe every TICK_DIV clk cycles; with TICK_DIV=1 the strobe SHALL be high every cycle.
REQ-012 The FSM SHALL have five states: DISARMED, WATCH, COUNT, ALARM and HOLDOFF.
REQ-013 `active` SHALL be 1 only in ALARM, and SHALL be driven directly from a state register with no combinational path from inputs.
REQ-014 DISARMED: counters SHALL be held at 0; RUN=1 SHALL move the FSM to WATCH on the next edge.
REQ-015 WATCH: on a tick with ws=1, the FSM SHALL go to COUNT, set the window counter to 1 and latch max(DTF,1) as the target; RUN=0 SHALL go to DISARMED.
REQ-016 COUNT: on each tick with ws=1 the window counter SHALL increment; when ws=1 and counter==target, the next state SHALL be ALARM.
REQ-017 Consequently, `active` SHALL rise on the edge of the target-th consecutive tick with ws=1 (DTF=0 behaves as DTF=1).
REQ-018 COUNT: a tick with ws=0 SHALL clear the counter and return the FSM to WATCH.
REQ-019 DTF changes during COUNT SHALL be ignored, because the target was latched on entry.
REQ-020 COUNT: CLR_WC=1 (any cycle, tick or not) SHALL clear the counter and return the FSM to WATCH; this SHALL take priority over counting and over the ALARM transition.
REQ-021 COUNT: RUN=0 SHALL return the FSM to DISARMED, with priority over CLR_WC.
REQ-022 ALARM SHALL be latched: ws, CLR_WC and RUN SHALL be ignored; only restart=1 or reset SHALL leave ALARM.
REQ-023 ALARM with restart=1: the FSM SHALL go to HOLDOFF, load the hold counter with RTR, and set `active`=0 on that same edge.
REQ-024 HOLDOFF: ws SHALL be ignored, and the hold counter SHALL decrement on each tick.
REQ-025 HOLDOFF: when the hold counter is 0, the next state SHALL be WATCH if RUN=1, otherwise DISARMED.
REQ-026 RTR=0 SHALL give a one-cycle HOLDOFF.
REQ-027 restart SHALL have no effect outside ALARM.
REQ-028 CLR_WC SHALL have no effect outside COUNT.
REQ-029 The window counter SHALL be 5 bits and SHALL never wrap, because it stops at the target.
REQ-030 The hold counter SHALL be 6 bits and SHALL never underflow.

Reset
REQ-031 rst=0 SHALL asynchronously force: state DISARMED, all counters and the prescaler to 0, the latched target to 1, and `active`=0.
REQ-032 Reset deassertion SHALL take effect at the first clk edge with rst=1.
REQ-033 Reset asserted mid-COUNT, mid-ALARM or mid-HOLDOFF SHALL abandon the operation immediately, with no pending alarm.

Verification (TICK_DIV=1, 10 ns clock)
REQ-034 Reset then RUN=1, DTF=12, ws held 1 -> `active` rises on the 12th edge with ws=1 in WATCH/COUNT, and stays 1 after ws drops.
REQ-035 DTF=7, ws=1 for 5 ticks, then ws=0 for 1 tick, then ws=1 for 7 ticks -> no alarm during the first burst; `active`=1 after the 7th tick of the second burst.
REQ-036 In ALARM, pulse restart with RTR=12 and ws=1 -> `active`=0 on the restart edge; the FSM returns to WATCH after 12 ticks, then the alarm re-fires after DTF more ticks.
REQ-037 In COUNT at counter=4 with DTF=12, assert CLR_WC for one cycle -> counter=0, state WATCH, no alarm.
REQ-038 DTF=0 and RTR=0 corner: one ws tick -> alarm; restart -> one-cycle HOLDOFF, then WATCH.
REQ-039 Assert rst=0 mid-ALARM -> `active`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/top_alarm.sv
// Intrusion alarm: a prescaled tick drives a five-state FSM that fires after
// DTF consecutive ws ticks, latches until restart, then holds off for RTR ticks.
module top_alarm #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       ws,
    input  logic       CLR_WC,
    input  logic       RUN,
    input  logic [4:0] DTF,
    input  logic [5:0] RTR,
    output logic       active
);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_WATCH,
        S_COUNT,
        S_ALARM,
        S_HOLDOFF
    } state_t;

    state_t      r_state;
    logic [15:0] r_pre;
    logic [4:0]  r_wc;
    logic [4:0]  r_target;
    logic [5:0]  r_hold;
    logic        r_active;

    logic        w_tick;
    logic [4:0]  w_dtf_eff;
    logic [4:0]  w_wc_nxt;

    assign w_tick    = (r_pre == 16'(TICK_DIV - 1));
    assign w_dtf_eff = (DTF == 5'd0) ? 5'd1 : DTF;
    assign w_wc_nxt  = r_wc + 5'd1;
    assign active    = r_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // The first qualifying tick counts as tick 1, so a target of 1 skips COUNT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_DISARMED;
            r_wc     <= '0;
            r_hold   <= '0;
            r_target <= 5'd1;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    r_wc     <= '0;
                    r_hold   <= '0;
                    r_active <= 1'b0;
                    if (RUN) r_state <= S_WATCH;
                end
                S_WATCH: begin
                    r_wc <= '0;
                    if (!RUN) begin
                        r_state <= S_DISARMED;
                    end else if (w_tick && ws) begin
                        r_target <= w_dtf_eff;
                        r_wc     <= 5'd1;
                        if (w_dtf_eff == 5'd1) begin
                            r_state  <= S_ALARM;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (!RUN) begin
                        r_state <= S_DISARMED;
                        r_wc    <= '0;
                    end else if (CLR_WC) begin
                        r_state <= S_WATCH;
                        r_wc    <= '0;
                    end else if (w_tick) begin
                        if (!ws) begin
                            r_state <= S_WATCH;
                            r_wc    <= '0;
                        end else begin
                            r_wc <= w_wc_nxt;
                            if (w_wc_nxt == r_target) begin
                                r_state  <= S_ALARM;
                                r_active <= 1'b1;
                            end
                        end
                    end
                end
                S_ALARM: begin
                    if (restart) begin
                        r_state  <= S_HOLDOFF;
                        r_hold   <= RTR;
                        r_wc     <= '0;
                        r_active <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold == 6'd0) begin
                        r_state <= RUN ? S_WATCH : S_DISARMED;
                    end else if (w_tick) begin
                        r_hold <= r_hold - 6'd1;
                    end
                end
                default: begin
                    r_state  <= S_DISARMED;
                    r_wc     <= '0;
                    r_hold   <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_alarm.sv
// Vector-table bench for top_alarm; a second instance with TICK_DIV=3
// checks the prescaler pacing.
module tb_top_alarm;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart, ws, CLR_WC, RUN;
    logic [4:0] DTF;
    logic [5:0] RTR;
    logic       active, active3;

    always #5 clk = ~clk;

    top_alarm #(.TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .restart(restart), .ws(ws), .CLR_WC(CLR_WC),
        .RUN(RUN), .DTF(DTF), .RTR(RTR), .active(active)
    );

    top_alarm #(.TICK_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .restart(restart), .ws(ws), .CLR_WC(CLR_WC),
        .RUN(RUN), .DTF(DTF), .RTR(RTR), .active(active3)
    );

    typedef struct {
        logic       rs;
        logic       w;
        logic       c;
        logic       r;
        logic [4:0] d;
        logic [5:0] t;
        logic       e;
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int idx, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d]: active=%b expected=%b", name, idx, got, want);
        end
    endtask

    task automatic add(input int n, input logic rs, input logic w, input logic c,
                       input logic r, input logic [4:0] d, input logic [5:0] t,
                       input logic e);
        vec_t v;
        v = '{rs: rs, w: w, c: c, r: r, d: d, t: t, e: e};
        repeat (n) vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expected output, sample after the edge.
    task automatic apply(input vec_t v, input int idx);
        logic want;
        restart = v.rs; ws = v.w; CLR_WC = v.c; RUN = v.r; DTF = v.d; RTR = v.t;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("vec", idx, active, want);
    endtask

    initial begin
        logic [5:0] exp3;
        rst = 1'b0; restart = 0; ws = 0; CLR_WC = 0; RUN = 0; DTF = '0; RTR = '0;

        //   n  rs w  c  r  dtf rtr exp
        add(1,  0, 0, 0, 1, 12, 0,  0);
        add(11, 0, 1, 0, 1, 12, 0,  0);
        add(1,  0, 1, 0, 1, 12, 0,  1);
        add(3,  0, 0, 0, 1, 12, 0,  1);
        add(2,  0, 0, 1, 0, 12, 0,  1);
        add(1,  1, 1, 0, 1, 12, 0,  0);
        add(1,  0, 1, 0, 1, 7,  0,  0);
        add(5,  0, 1, 0, 1, 7,  0,  0);
        add(1,  0, 0, 0, 1, 7,  0,  0);
        add(1,  0, 1, 0, 1, 7,  0,  0);
        add(5,  0, 1, 0, 1, 2,  0,  0);
        add(1,  0, 1, 0, 1, 2,  0,  1);
        add(1,  1, 1, 0, 1, 3,  12, 0);
        add(15, 1, 1, 0, 1, 3,  12, 0);
        add(1,  1, 1, 0, 1, 3,  12, 1);
        add(1,  1, 0, 0, 0, 3,  2,  0);
        add(3,  0, 0, 0, 0, 3,  2,  0);
        add(2,  0, 1, 0, 0, 3,  2,  0);
        add(1,  0, 0, 0, 1, 12, 0,  0);
        add(4,  0, 1, 0, 1, 12, 0,  0);
        add(1,  0, 1, 1, 1, 12, 0,  0);
        add(1,  0, 1, 1, 1, 12, 0,  0);
        add(10, 0, 1, 0, 1, 12, 0,  0);
        add(1,  0, 1, 0, 1, 12, 0,  1);
        add(1,  1, 0, 0, 1, 2,  0,  0);
        add(1,  0, 0, 0, 1, 2,  0,  0);
        add(1,  0, 1, 0, 1, 2,  0,  0);
        add(1,  0, 1, 1, 1, 2,  0,  0);
        add(1,  0, 1, 0, 1, 2,  0,  0);
        add(1,  0, 1, 0, 1, 2,  0,  1);
        add(1,  1, 0, 0, 1, 3,  0,  0);
        add(1,  0, 0, 0, 1, 3,  0,  0);
        add(1,  0, 1, 0, 1, 3,  0,  0);
        add(1,  0, 1, 1, 0, 3,  0,  0);
        add(1,  0, 1, 0, 1, 3,  0,  0);
        add(2,  0, 1, 0, 1, 3,  0,  0);
        add(1,  0, 1, 0, 1, 3,  0,  1);
        add(1,  1, 0, 0, 1, 0,  0,  0);
        add(1,  0, 0, 0, 1, 0,  0,  0);
        add(1,  0, 1, 0, 1, 0,  0,  1);
        add(1,  1, 1, 0, 1, 0,  0,  0);
        add(1,  0, 1, 0, 1, 0,  0,  0);
        add(1,  0, 1, 0, 1, 0,  0,  1);

        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, active, 1'b0);
        check("reset3", 0, active3, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset while latched in ALARM.
        restart = 0; ws = 1; RUN = 1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 0, active, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", 0, active, 1'b0);

        // Both instances restart from reset; the TICK_DIV=3 one fires on its 2nd tick.
        rst = 1'b1;
        exp3 = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            restart = 0; ws = 1; CLR_WC = 0; RUN = 1; DTF = 5'd2; RTR = '0;
            exp_q.push_back(i >= 2);
            @(posedge clk);
            #1;
            check("post_rst", i, active, exp_q.pop_front());
            check("div3", i, active3, exp3[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
